// File: rtl/fir_pkg.sv
// Shared types and width helpers for the parameterised FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StCompute} fir_state_t;

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned taps);
    return 2 * data_w + $clog2(taps);
  endfunction

  function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate: full-precision product added into a sign-extended accumulator.
module fir_mac #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AccW  = 19
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic signed [DataW-1:0] coef_i,
  input  logic signed [DataW-1:0] sample_i,
  output logic signed [AccW-1:0]  acc_o
);

  logic signed [2*DataW-1:0] prod;
  logic signed [AccW-1:0]    acc_d, acc_q;

  assign prod = coef_i * sample_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(AccW - 2 * DataW){prod[2*DataW-1]}}, prod};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_param.sv
// Sequential FIR filter: loads TAPS coefficients, then one MAC per cycle per accepted sample.
// Define FIR_SATURATE_EN to clamp the result to OUT_W bits instead of wrapping.
module fir_param
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    coef_enable,
  input  logic                    sample_enable,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    out_enable,
  output logic                    busy,
  output logic                    error
);

  localparam int unsigned AccW  = acc_width(DATA_W, TAPS);
  localparam int unsigned CntW  = $clog2(TAPS + 1);
  localparam int unsigned WideW = max_width(AccW, OUT_W) + 1;

  fir_state_t state_q, state_d;

  logic        [CntW-1:0]   count_q, idx_q;
  logic signed [DATA_W-1:0] coeff_q [TAPS];
  logic signed [DATA_W-1:0] x_q     [TAPS];
  logic signed [OUT_W-1:0]  data_out_q;
  logic                     out_enable_q, error_q;

  logic coef_start, coef_next, load_abort, sample_accept, mac_en, finish, err_d;
  logic signed [DATA_W-1:0] tap_coef, tap_sample;
  logic signed [AccW-1:0]   mac_acc;
  logic signed [WideW-1:0]  acc_ext;
  logic signed [OUT_W-1:0]  result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (coef_enable && !sample_enable) state_d = StLoad;
      StLoad: begin
        if (!coef_enable) begin
          state_d = StIdle;
        end else if (!sample_enable && count_q == CntW'(TAPS - 1)) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (coef_enable && !sample_enable) begin
          state_d = StLoad;
        end else if (sample_enable && !coef_enable) begin
          state_d = StCompute;
        end
      end
      StCompute: if (idx_q == CntW'(TAPS)) state_d = StReady;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    coef_start    = 1'b0;
    coef_next     = 1'b0;
    load_abort    = 1'b0;
    sample_accept = 1'b0;
    mac_en        = 1'b0;
    finish        = 1'b0;
    busy          = (state_q == StCompute);
    // Simultaneous enables, misplaced samples and coefficients mid-compute are all rejected.
    err_d = (coef_enable && sample_enable) || (sample_enable && state_q != StReady) ||
            (coef_enable && state_q == StCompute);
    unique case (state_q)
      StIdle:  coef_start = coef_enable && !sample_enable;
      StLoad: begin
        coef_next  = coef_enable && !sample_enable;
        load_abort = !coef_enable;
      end
      StReady: begin
        coef_start    = coef_enable && !sample_enable;
        sample_accept = sample_enable && !coef_enable;
      end
      StCompute: begin
        mac_en = (idx_q != CntW'(TAPS));
        finish = (idx_q == CntW'(TAPS));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      idx_q        <= '0;
      data_out_q   <= '0;
      out_enable_q <= 1'b0;
      error_q      <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        coeff_q[k] <= '0;
        x_q[k]     <= '0;
      end
    end else begin
      error_q      <= err_d;
      out_enable_q <= finish;
      if (finish) data_out_q <= result;
      if (coef_start) begin
        coeff_q[0] <= data_in;
        count_q    <= CntW'(1);
      end else if (coef_next) begin
        for (int k = 0; k < TAPS; k++) begin
          if (count_q == CntW'(k)) coeff_q[k] <= data_in;
        end
        count_q <= count_q + CntW'(1);
      end else if (load_abort) begin
        count_q <= '0;
      end
      if (sample_accept) begin
        x_q[0] <= data_in;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
        idx_q <= '0;
      end else if (mac_en) begin
        idx_q <= idx_q + CntW'(1);
      end
    end
  end

  always_comb begin
    tap_coef   = '0;
    tap_sample = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx_q == CntW'(k)) begin
        tap_coef   = coeff_q[k];
        tap_sample = x_q[k];
      end
    end
  end

  fir_mac #(
    .DataW(DATA_W),
    .AccW (AccW)
  ) u_mac (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (sample_accept),
    .en_i    (mac_en),
    .coef_i  (tap_coef),
    .sample_i(tap_sample),
    .acc_o   (mac_acc)
  );

  assign acc_ext = {{(WideW - AccW){mac_acc[AccW-1]}}, mac_acc};

`ifdef FIR_SATURATE_EN
  localparam logic signed [WideW-1:0] SatMax = (WideW'(1) << (OUT_W - 1)) - WideW'(1);
  localparam logic signed [WideW-1:0] SatMin = -(WideW'(1) << (OUT_W - 1));

  always_comb begin
    if (acc_ext > SatMax) begin
      result = OUT_W'(SatMax);
    end else if (acc_ext < SatMin) begin
      result = OUT_W'(SatMin);
    end else begin
      result = OUT_W'(acc_ext);
    end
  end
`else
  assign result = OUT_W'(acc_ext);
`endif

  assign data_out   = data_out_q;
  assign out_enable = out_enable_q;
  assign error      = error_q;

endmodule

// File: tb/tb_fir_param.sv
// Scoreboard bench for fir_param: directed protocol cases plus randomized samples vs. a dot-product model.
module tb_fir_param;

  localparam int TAPS = 5;
  localparam int LAT  = TAPS + 1;

  logic        clk = 1'b0;
  logic        reset, coef_enable, sample_enable;
  logic [7:0]  data_in;
  logic [15:0] data_out;
  logic        out_enable, busy, error;

  fir_param #(
    .DATA_W(8),
    .TAPS  (TAPS),
    .OUT_W (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .coef_enable  (coef_enable),
    .sample_enable(sample_enable),
    .data_out     (data_out),
    .out_enable   (out_enable),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          mc[TAPS];
  int          mx[TAPS];
  int          cv[TAPS];
  logic [15:0] last_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain dot product of coefficients and the last TAPS samples, then fit to 16 bits.
  function automatic logic [15:0] model_out();
    longint acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(mc[k]) * longint'(mx[k]);
`ifdef FIR_SATURATE_EN
    if (acc > 32767) return 16'h7fff;
    if (acc < -32768) return 16'h8000;
`endif
    return acc[15:0];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_enable === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_out_enable", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          check("data_out", {16'd0, data_out}, {16'd0, mon_e.val});
          check("latency", cyc, mon_e.due);
          last_out = mon_e.val;
        end
      end
    end
  end

  task automatic drive(input logic ce, input logic se, input logic [7:0] d, input logic exp_err,
                       input string nm);
    @(negedge clk);
    coef_enable   = ce;
    sample_enable = se;
    data_in       = d;
    @(posedge clk);
    #1;
    coef_enable   = 1'b0;
    sample_enable = 1'b0;
    check({nm, "_error"}, {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset         = 1'b1;
    coef_enable   = 1'b0;
    sample_enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expq.delete();
    for (int k = 0; k < TAPS; k++) begin
      mc[k] = 0;
      mx[k] = 0;
    end
    last_out = '0;
    check({nm, "_data_out"}, {16'd0, data_out}, 32'd0);
    check({nm, "_out_enable"}, {31'd0, out_enable}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic load(input int n, input string nm);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'(cv[i]), 1'b0, nm);
    if (n == TAPS) begin
      for (int k = 0; k < TAPS; k++) mc[k] = cv[k];
    end
  endtask

  task automatic sample(input logic [7:0] d, input logic exp_err, input string nm);
    drive(1'b0, 1'b1, d, exp_err, nm);
    if (!exp_err) begin
      for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = int'($signed(d));
      expq.push_back('{val: model_out(), due: cyc + LAT});
      check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({nm, "_drain"}, expq.size(), 32'd0);
    @(posedge clk);
    #2;
    check({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_hold"}, {16'd0, data_out}, {16'd0, last_out});
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 1'b0, nm);
  endtask

  logic [7:0] r;

  initial begin
    reset = 1'b1; coef_enable = 1'b0; sample_enable = 1'b0; data_in = '0; last_out = '0;
    do_reset("reset");

    // Basic impulse-style response: 4, 9, 15, 22, 30.
    cv = '{4, 5, 6, 7, 8};
    load(TAPS, "load");
    for (int i = 0; i < TAPS; i++) begin
      sample(8'd1, 1'b0, "ones");
      wait_done("ones");
    end

    // Both enables in READY: rejected, nothing altered.
    drive(1'b1, 1'b1, 8'd9, 1'b1, "both_ready");
    sample(8'd2, 1'b0, "after_both");
    wait_done("after_both");

    // Sample and coefficient arriving mid-compute are dropped.
    do_reset("reset2");
    load(TAPS, "load2");
    sample(8'd1, 1'b0, "acc1");
    idle(1, "gap");
    sample(8'd5, 1'b1, "sample_in_compute");
    drive(1'b1, 1'b0, 8'd3, 1'b1, "coef_in_compute");
    wait_done("compute_viol");
    sample(8'd1, 1'b0, "acc2");
    wait_done("acc2");

    // Largest positive inputs: wraps or saturates.
    do_reset("reset3");
    cv = '{127, 127, 127, 127, 127};
    load(TAPS, "load_max");
    for (int i = 0; i < TAPS; i++) begin
      sample(8'd127, 1'b0, "max");
      wait_done("max");
    end

    // Partial load aborts back to IDLE; next full load restarts at index 0.
    do_reset("reset4");
    cv = '{4, 5, 6, 7, 8};
    load(3, "partial");
    idle(1, "abort");
    sample(8'd1, 1'b1, "sample_idle");
    idle(10, "after_abort");
    check("abort_busy", {31'd0, busy}, 32'd0);
    load(TAPS, "reload");
    sample(8'd1, 1'b0, "reload_s");
    wait_done("reload_s");

    // Reset two cycles into a computation kills it.
    do_reset("reset5");
    load(TAPS, "load5");
    sample(8'd1, 1'b0, "pre");
    wait_done("pre");
    sample(8'd1, 1'b0, "killed");
    idle(1, "killed_gap");
    do_reset("reset_mid_compute");
    sample(8'd1, 1'b1, "sample_after_reset");
    idle(10, "after_reset");
    check("after_reset_busy", {31'd0, busy}, 32'd0);

    // Randomized coefficients and samples, occasional reloads.
    do_reset("reset6");
    for (int k = 0; k < TAPS; k++) begin
      r = 8'($urandom);
      cv[k] = int'($signed(r));
    end
    load(TAPS, "rand_load");
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < TAPS; k++) begin
          r = 8'($urandom);
          cv[k] = int'($signed(r));
        end
        load(TAPS, "rand_reload");
      end
      r = 8'($urandom);
      sample(r, 1'b0, "rand");
      wait_done("rand");
    end

    check("final_queue", expq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
